// File: rtl/cic_integ_decim.sv
// CIC integrator chain plus rate decimator.
// STAGES cascaded wrap-around accumulators feed a sample counter that
// forwards every DECIM-th integrated sample to the comb section.
//
// Valid semantics: a sample is taken on every clock edge where its valid is
// high (din_valid at the input, v[k-1] between stages). There is no ready
// or backpressure. dout_valid is a one-cycle strobe, and dout holds its
// value between strobes.
module cic_integ_decim #(
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 25,
  parameter int STAGES     = 3,
  parameter int DECIM      = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_valid
);

  localparam int CNT_W     = $clog2(DECIM);
  localparam int MIN_WIDTH = DIN_WIDTH + STAGES * $clog2(DECIM * DIFF_DELAY);

  // Refuse to elaborate if the accumulators cannot hold the CIC bit growth.
  if (DOUT_WIDTH < MIN_WIDTH) begin : g_width_check
    $error("cic_integ_decim: DOUT_WIDTH too small for the CIC bit growth");
  end

  logic signed [DOUT_WIDTH-1:0] din_ext;
  logic signed [DOUT_WIDTH-1:0] acc     [STAGES];
  logic signed [DOUT_WIDTH-1:0] stage_x [STAGES];
  logic        [STAGES-1:0]     stage_v;
  logic        [STAGES-1:0]     v;
  logic        [CNT_W-1:0]      cnt;

  // Sign-extend the input sample to the accumulator width.
  assign din_ext = DOUT_WIDTH'(din);

  // Stage k takes the extended input (k = 0) or the previous accumulator.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
    if (k == 0) begin : g_first
      assign stage_x[k] = din_ext;
      assign stage_v[k] = din_valid;
    end else begin : g_chain
      assign stage_x[k] = acc[k-1];
      assign stage_v[k] = v[k-1];
    end
  end

  // Integrators: each stage adds its input modulo 2^DOUT_WIDTH, freezes
  // while its input valid is low, and passes the valid on one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        acc[k] <= '0;
      end
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_v[k]) begin
          acc[k] <= acc[k] + stage_x[k];
        end
      end
      v <= stage_v;
    end
  end

  // Decimator: count samples leaving the last stage and forward every
  // DECIM-th one. The phase tracks samples, not cycles, so gaps in the
  // input do not disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (v[STAGES-1]) begin
        if (cnt == CNT_W'(DECIM - 1)) begin
          cnt        <= '0;
          dout       <= acc[STAGES-1];
          dout_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_integ_decim.sv
// Testbench for cic_integ_decim. Two instances share the stimulus: one uses
// the default parameters (3 stages, R=8) and one uses STAGES=1, DECIM=2.
// The reference model keeps every accepted sample. The integrator chain
// output after n samples is the binomial-weighted sum
// sum x_i * C(n-i+S-1, S-1), taken mod 2^W.
module tb_cic_integ_decim;

  localparam int W  = 25;
  localparam int S  = 3;
  localparam int R  = 8;
  localparam int S1 = 1;
  localparam int R1 = 2;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] din = '0;
  logic din_valid = 1'b0;
  logic signed [W-1:0] dout, dout1;
  logic dout_valid, dout1_valid;

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  cic_integ_decim #(.DIN_WIDTH(16), .DOUT_WIDTH(W), .STAGES(S), .DECIM(R), .DIFF_DELAY(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid)
  );

  cic_integ_decim #(.DIN_WIDTH(16), .DOUT_WIDTH(W), .STAGES(S1), .DECIM(R1), .DIFF_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout1), .dout_valid(dout1_valid)
  );

  // Scoreboard state.
  int n_checks = 0;
  int n_fail   = 0;
  longint hist[$];
  logic [W-1:0] exp_q[$], exp1_q[$], obs_q[$], obs1_q[$];
  int exp_t[$], exp1_t[$], obs_t[$], obs1_t[$];
  logic [W-1:0] cyc_dout[$];
  logic cyc_valid[$];

  function automatic longint binom(input int m, input int k);
    longint r = 1;
    for (int i = 1; i <= k; i++) r = r * longint'(m - k + i) / longint'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] model_out(input int stages);
    longint sum = 0;
    int n = hist.size();
    for (int i = 0; i < n; i++) sum += hist[i] * binom(n - 1 - i + stages - 1, stages - 1);
    return W'(sum);
  endfunction

  // Driver: one clock per call. It records outputs at the falling edge,
  // then applies new inputs and updates the model.
  task automatic tick(input logic r, input logic signed [15:0] d, input logic v);
    @(negedge clk);
    if (dout_valid === 1'b1) begin obs_q.push_back(dout); obs_t.push_back(ncyc); end
    if (dout1_valid === 1'b1) begin obs1_q.push_back(dout1); obs1_t.push_back(ncyc); end
    cyc_dout.push_back(dout);
    cyc_valid.push_back(dout_valid);
    rst = r; din = d; din_valid = v;
    if (r) hist.delete();
    else if (v) begin
      hist.push_back(longint'(d));
      if (hist.size() % R == 0) begin exp_q.push_back(model_out(S)); exp_t.push_back(ncyc + S + 1); end
      if (hist.size() % R1 == 0) begin exp1_q.push_back(model_out(S1)); exp1_t.push_back(ncyc + S1 + 1); end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete(); exp1_q.delete(); obs_q.delete(); obs1_q.delete();
    exp_t.delete(); exp1_t.delete(); obs_t.delete(); obs1_t.delete();
    cyc_dout.delete(); cyc_valid.delete();
  endtask

  task automatic do_reset();
    tick(1'b1, '0, 1'b0);
    tick(1'b1, '0, 1'b0);
    clear_sb();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    idle(1);
    n_checks++;
    if (dout !== '0 || dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_default: dout=%0d valid=%b, required 0/0", dout, dout_valid);
    end
    n_checks++;
    if (dout1 !== '0 || dout1_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_sweep: dout=%0d valid=%b, required 0/0", dout1, dout1_valid);
    end
  endtask

  task automatic test_step();
    int known[3] = '{120, 816, 2600};
    do_reset();
    repeat (24) tick(1'b0, 16'sd1, 1'b1);
    idle(8);
    n_checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() !== 3) begin
      n_fail++; $display("FAIL step_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== W'(known[i])) begin
        n_fail++; $display("FAIL step_value[%0d]: got %0d, required %0d", i, (i < obs_q.size()) ? $signed(obs_q[i]) : -1, known[i]);
      end
      n_checks++;
      if (i >= obs_t.size() || i >= exp_t.size() || obs_t[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL step_time[%0d]: got cycle %0d, required %0d", i, (i < obs_t.size()) ? obs_t[i] : -1, (i < exp_t.size()) ? exp_t[i] : -1);
      end
    end
    n_checks++;
    if (obs_t.size() == 3 && (obs_t[1] - obs_t[0] !== 8 || obs_t[2] - obs_t[1] !== 8)) begin
      n_fail++; $display("FAIL step_spacing: got %0d/%0d cycles, required 8/8", obs_t[1] - obs_t[0], obs_t[2] - obs_t[1]);
    end
  endtask

  task automatic test_impulse();
    int known[3] = '{36, 136, 300};
    logic [W-1:0] held;
    int k;
    do_reset();
    tick(1'b0, 16'sd1, 1'b1);
    repeat (23) tick(1'b0, 16'sd0, 1'b1);
    idle(8);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== W'(known[i]) || i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL impulse[%0d]: got %0d, required %0d", i, (i < obs_q.size()) ? $signed(obs_q[i]) : -1, known[i]);
      end
    end
    held = '0;
    k = 0;
    for (int i = 0; i < cyc_valid.size(); i++) begin
      if (cyc_valid[i] === 1'b1) begin
        if (k < exp_q.size()) held = exp_q[k];
        k++;
      end else begin
        n_checks++;
        if (cyc_dout[i] !== held) begin
          n_fail++; $display("FAIL impulse_hold: cycle %0d dout=%0d, required %0d", i, $signed(cyc_dout[i]), $signed(held));
        end
      end
    end
  endtask

  task automatic test_gapped();
    int known[3] = '{120, 816, 2600};
    do_reset();
    for (int i = 0; i < 48; i++) tick(1'b0, 16'sd1, (i % 2) == 0);
    idle(8);
    n_checks++;
    if (obs_q.size() !== 3) begin
      n_fail++; $display("FAIL gap_count: got %0d strobes, required 3", obs_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== W'(known[i]) || i >= obs_t.size() || obs_t[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL gap[%0d]: got %0d at %0d, required %0d at %0d", i, (i < obs_q.size()) ? $signed(obs_q[i]) : -1, (i < obs_t.size()) ? obs_t[i] : -1, known[i], exp_t[i]);
      end
    end
    n_checks++;
    if (obs_t.size() == 3 && (obs_t[1] - obs_t[0] !== 16 || obs_t[2] - obs_t[1] !== 16)) begin
      n_fail++; $display("FAIL gap_spacing: got %0d/%0d cycles, required 16/16", obs_t[1] - obs_t[0], obs_t[2] - obs_t[1]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (40) tick(1'b0, -16'sd32768, 1'b1);
    idle(8);
    n_checks++;
    if (obs_q.size() !== 5 || exp_q.size() !== 5) begin
      n_fail++; $display("FAIL wrap_count: got %0d strobes, required 5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_t[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL wrap[%0d]: got %0d, required %0d", i, $signed(obs_q[i]), $signed(exp_q[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) tick(1'b0, 16'sd1, 1'b1);
    tick(1'b1, 16'sd1, 1'b1);
    clear_sb();
    tick(1'b0, 16'sd1, 1'b1);
    n_checks++;
    if (cyc_dout[0] !== '0 || cyc_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_out: dout=%0d valid=%b, required 0/0", cyc_dout[0], cyc_valid[0]);
    end
    repeat (7) tick(1'b0, 16'sd1, 1'b1);
    idle(8);
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== W'(120) || exp_t.size() !== 1 || obs_t[0] !== exp_t[0]) begin
      n_fail++; $display("FAIL mid_reset_resume: got %0d strobes first=%0d, required 1 strobe of 120",
                         obs_q.size(), (obs_q.size() > 0) ? $signed(obs_q[0]) : -1);
    end
  endtask

  task automatic test_sweep();
    int known[3] = '{6, 12, 18};
    do_reset();
    repeat (6) tick(1'b0, 16'sd3, 1'b1);
    idle(4);
    n_checks++;
    if (obs1_q.size() !== 3) begin
      n_fail++; $display("FAIL sweep_count: got %0d strobes, required 3", obs1_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= obs1_q.size() || obs1_q[i] !== W'(known[i]) || i >= obs1_t.size() || obs1_t[i] !== exp1_t[i]) begin
        n_fail++; $display("FAIL sweep[%0d]: got %0d at %0d, required %0d at %0d", i, (i < obs1_q.size()) ? $signed(obs1_q[i]) : -1, (i < obs1_t.size()) ? obs1_t[i] : -1, known[i], exp1_t[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    while (hist.size() < 64) begin
      tick(1'b0, 16'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0);
    end
    idle(8);
    n_checks++;
    if (obs_q.size() !== exp_q.size() || obs1_q.size() !== exp1_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d/%0d strobes, required %0d/%0d", obs_q.size(), obs1_q.size(), exp_q.size(), exp1_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_t[i] !== exp_t[i]) begin
        n_fail++; $display("FAIL rand[%0d]: got %0d at %0d, required %0d at %0d", i, $signed(obs_q[i]), obs_t[i], $signed(exp_q[i]), exp_t[i]);
      end
    end
    for (int i = 0; i < obs1_q.size() && i < exp1_q.size(); i++) begin
      n_checks++;
      if (obs1_q[i] !== exp1_q[i] || obs1_t[i] !== exp1_t[i]) begin
        n_fail++; $display("FAIL rand_sweep[%0d]: got %0d at %0d, required %0d at %0d", i, $signed(obs1_q[i]), obs1_t[i], $signed(exp1_q[i]), exp1_t[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_impulse();
    test_gapped();
    test_wrap();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_integ_decim.md
# cic_integ_decim

Integrator chain and rate decimator for the CIC decimation filter. Accepts input samples at the clock rate (qualified by a valid strobe), runs them through STAGES cascaded wrap-around accumulators, and emits one sample per DECIM accepted inputs. Sits directly upstream of the comb section, which consumes `dout` on `dout_valid`.

## Interface
- `DIN_WIDTH`, default 16: signed input sample width.
- `DOUT_WIDTH`, default 25: accumulator and output width; must be ≥ DIN_WIDTH + STAGES·ceil(log2(DECIM·DIFF_DELAY)). The default is 16 + 3·3.
- `STAGES`, default 3: number of integrator stages, ≥ 1.
- `DECIM`, default 8: decimation ratio R, ≥ 2.
- `DIFF_DELAY`, default 1: comb differential delay M; used only for the width requirement.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `din` input DIN_WIDTH: signed input sample.
- `din_valid` input 1: `din` is accepted on any cycle where this is high.
- `dout` output DOUT_WIDTH: signed decimated integrator output.
- `dout_valid` output 1: one-cycle strobe marking a new `dout`.

## Operation
- **Input extension:** `din` is sign-extended to DOUT_WIDTH before stage 0.
- **Integrator stage k** (k = 0..STAGES-1):
  - Holds register `acc[k]` and valid flag `v[k]`.
  - Stage input `x` is the extended `din` for k = 0; otherwise it is `acc[k-1]`.
  - Stage input valid is `din_valid` for k = 0; otherwise it is `v[k-1]`.
  - When the stage input valid is high: `acc[k] <= acc[k] + x`. Otherwise `acc[k]` holds.
  - `v[k] <= ` stage input valid, every cycle.
- **Arithmetic:** two's-complement modulo 2^DOUT_WIDTH. Overflow wraps silently, with no saturation and no flag. Wrap is required for CIC correctness.
- **Decimation counter:** `cnt`, range 0..DECIM-1, width ceil(log2(DECIM)).
  - Advances only on cycles where `v[STAGES-1]` = 1.
  - If `cnt` == DECIM-1: `dout <= acc[STAGES-1]` (the updated value visible that cycle), `dout_valid <= 1`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`, `dout_valid <= 0`, `dout` holds.
  - On cycles with `v[STAGES-1]` = 0: `dout_valid <= 0`, `dout` holds.
- **Gaps:** `din_valid` gaps are allowed anywhere. Each stage freezes while its input valid is low. Decimation phase counts accepted samples only, not cycles.
- **Decimation phase:** the first output after reset corresponds to the DECIM-th accepted sample. There is no external phase-alignment input.
- **Reset:** `rst` high clears all `acc[k]`, all `v[k]`, `cnt`, `dout` and `dout_valid` to 0 on the next edge.
  - Samples in flight are discarded.
  - `din_valid` during a `rst` cycle is ignored.
  - The first post-reset sample is the first one with `din_valid` high and `rst` low.
- **Simultaneous events:** `rst` has priority over everything. `din_valid` on the same cycle as `dout_valid` is normal pipelined operation; no stall, no backpressure.

## Timing
- **Reset values:** `dout` = 0, `dout_valid` = 0.
- **Stage latency:** each stage adds one register, so `acc[STAGES-1]` reflects an accepted sample STAGES cycles after acceptance.
- **Output latency:** `dout_valid` asserts STAGES+1 cycles after the edge that accepts the DECIM-th sample. Default: 4 cycles.
- **Throughput:** one input per clock. `dout_valid` is at most one cycle in every DECIM, and never on two consecutive cycles.
- **Output hold:** `dout` is stable between strobes. The downstream comb samples it on `dout_valid`.

## Test plan
- **Step response, defaults:** after reset, `din` = 1 with `din_valid` held high.
  - Strobe 1 carries `dout` = 120 (n=8: n(n+1)(n+2)/6).
  - Strobe 2 carries 816 (n=16); strobe 3 carries 2600 (n=24).
  - Strobes are spaced exactly 8 cycles apart; the first is 4 cycles after the 8th acceptance.
- **Impulse:** `din` = 1 for one accepted sample, then 0.
  - Outputs are 36, 136, 300 (C(n+1,2) at n=8, 16, 24).
  - `dout` holds between strobes.
- **Gapped input:** same stimulus as the step test, but with `din_valid` toggling 1,0,1,0.
  - Identical `dout` sequence 120, 816, 2600.
  - Strobes spaced 16 cycles apart; the first arrives 4 cycles after the 8th acceptance.
- **Wrap-around:** DOUT_WIDTH=25, `din` = -32768 constant.
  - Each `dout` equals the exact result mod 2^25, sign-interpreted. Check against a model: -32768·n(n+1)(n+2)/6 mod 2^25.
  - No X values, no saturation.
- **Reset mid-operation:** assert `rst` for 1 cycle after 5 accepted samples (step input), while `v[]` is still non-zero.
  - Next cycle: `dout` = 0, `dout_valid` = 0, `cnt` = 0.
  - Resuming the step input reproduces exactly 120 as the first strobe, 8 acceptances later.
- **Parameter sweep:** STAGES=1, DECIM=2 with a constant step of 3.
  - Outputs are 6, 12, 18.
  - `dout_valid` is 2 cycles after every second acceptance.
